sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO controller. It is the next generation of the SD-host tx/rx buffering and is used on paths where the producer and consumer share one clock domain. Beyond basic full/empty operation it adds:
- fill-level output
- programmable almost-full/almost-empty thresholds
- synchronous flush
- sticky overflow/underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode

---
 rtl/sync_fifo_ctrl_if.sv | 36 +++
 rtl/sync_fifo_ctrl.sv | 98 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/data bundle between a FIFO user and sync_fifo_ctrl.
// The master drives writes, reads and control; the slave returns data, level and status.
interface sync_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZE_BITS  = 3
);
    logic [DATA_WIDTH-1:0] data;
    logic                  write_enable;
    logic                  read_enable;
    logic                  flush;
    logic                  clear_errors;
    logic [SIZE_BITS:0]    almost_full_level;
    logic [SIZE_BITS:0]    almost_empty_level;
    logic [DATA_WIDTH-1:0] q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [SIZE_BITS:0]    level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data, write_enable, read_enable, flush, clear_errors,
               almost_full_level, almost_empty_level,
        input  q, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  data, write_enable, read_enable, flush, clear_errors,
               almost_full_level, almost_empty_level,
        output q, fifo_full, fifo_empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill level, thresholds, flush, sticky error
// flags and a choice of registered-output or first-word-fall-through read data.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_SIZE  = 8,
    parameter int unsigned SIZE_BITS  = 3,
    parameter int unsigned FWFT       = 0
) (
    input  logic          clock,
    input  logic          reset,
    sync_fifo_ctrl_if.slave bus
);
    localparam int unsigned LVL_W = SIZE_BITS + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];
    logic [SIZE_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [SIZE_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc_c, wr_acc_c, rd_fire_c, wr_fire_c;

    // A write while full only gets in when a read frees the slot in the same cycle.
    always_comb begin
        rd_acc_c  = bus.read_enable & ~empty_q;
        wr_acc_c  = bus.write_enable & (~full_q | rd_acc_c);
        rd_fire_c = rd_acc_c & ~bus.flush;
        wr_fire_c = wr_acc_c & ~bus.flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire_c) wr_ptr_d = wr_ptr_q + SIZE_BITS'(1);
            if (rd_fire_c) rd_ptr_d = rd_ptr_q + SIZE_BITS'(1);
            if (wr_fire_c && !rd_fire_c)      level_d = level_q + LVL_W'(1);
            else if (rd_fire_c && !wr_fire_c) level_d = level_q - LVL_W'(1);
        end
        full_d  = (level_d == LVL_W'(FIFO_SIZE));
        empty_d = (level_d == '0);
        // Sticky flags: a new error in the clearing cycle still lands.
        ovf_d = (ovf_q & ~bus.clear_errors) | (bus.write_enable & ~wr_acc_c & ~bus.flush);
        udf_d = (udf_q & ~bus.clear_errors) | (bus.read_enable & empty_q & ~bus.flush);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_fire_c) mem_q[wr_ptr_q] <= bus.data;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.q = mem_q[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] q_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)          q_q <= '0;
            else if (bus.flush) q_q <= '0;
            else if (rd_fire_c) q_q <= mem_q[rd_ptr_q];
        end
        assign bus.q = q_q;
    end

    assign bus.level        = level_q;
    assign bus.fifo_full    = full_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.almost_full  = (level_q >= bus.almost_full_level);
    assign bus.almost_empty = (level_q <= bus.almost_empty_level);
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO share one stimulus
// stream and are compared against a queue-based reference model.
module tb_sync_fifo_ctrl;
    localparam int unsigned DW    = 32;
    localparam int unsigned SB    = 3;
    localparam int unsigned DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .SIZE_BITS(SB)) b0 ();
    sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .SIZE_BITS(SB)) b1 ();

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(DEPTH), .SIZE_BITS(SB), .FWFT(0))
        dut_std (.clock(clock), .reset(reset), .bus(b0.slave));
    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(DEPTH), .SIZE_BITS(SB), .FWFT(1))
        dut_fwft (.clock(clock), .reset(reset), .bus(b1.slave));

    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_udf;
    logic [SB:0]   afl, ael;
    int            total = 0;
    int            bad   = 0;
    logic          rd_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit we, input bit re, input bit fl, input bit ce, input logic [DW-1:0] d);
        b0.write_enable = we; b1.write_enable = we;
        b0.read_enable  = re; b1.read_enable  = re;
        b0.flush        = fl; b1.flush        = fl;
        b0.clear_errors = ce; b1.clear_errors = ce;
        b0.data         = d;  b1.data         = d;
    endtask

    task automatic set_thr(input logic [SB:0] af, input logic [SB:0] ae);
        afl = af; ael = ae;
        b0.almost_full_level  = af; b1.almost_full_level  = af;
        b0.almost_empty_level = ae; b1.almost_empty_level = ae;
    endtask

    task automatic model_clear();
        mdl.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock of stimulus; the model advances just after the edge it describes.
    task automatic step(input bit we, input bit re, input bit fl, input bit ce, input logic [DW-1:0] d);
        int  sz;
        bit  rd, wr;
        drive(we, re, fl, ce, d);
        @(posedge clock);
        #1;
        sz = mdl.size();
        if (ce) begin m_ovf = 1'b0; m_udf = 1'b0; end
        if (fl) begin
            mdl.delete();
        end else begin
            rd = re && (sz > 0);
            wr = we && ((sz < DEPTH) || rd);
            if (rd) exp_q.push_back(mdl.pop_front());
            if (wr) mdl.push_back(d);
            if (we && !wr) m_ovf = 1'b1;
            if (re && sz == 0) m_udf = 1'b1;
        end
    endtask

    // Standard-mode data is presented the cycle after an accepted read.
    always @(posedge clock or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= b0.read_enable & ~b0.fifo_empty & ~b0.flush;
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("level_std",  b0.level,        64'(mdl.size()));
            chk("level_fwft", b1.level,        64'(mdl.size()));
            chk("full",       b0.fifo_full,    64'(mdl.size() == DEPTH));
            chk("empty",      b0.fifo_empty,   64'(mdl.size() == 0));
            chk("empty_fwft", b1.fifo_empty,   64'(mdl.size() == 0));
            chk("almost_full",  b0.almost_full,  64'(mdl.size() >= int'(afl)));
            chk("almost_empty", b0.almost_empty, 64'(mdl.size() <= int'(ael)));
            chk("overflow",   b0.overflow,     64'(m_ovf));
            chk("underflow",  b0.underflow,    64'(m_udf));
            chk("ovf_fwft",   b1.overflow,     64'(m_ovf));
            chk("udf_fwft",   b1.underflow,    64'(m_udf));
            if (mdl.size() > 0) chk("fwft_q", b1.q, 64'(mdl[0]));
            if (rd_seen) begin
                if (exp_q.size() == 0) chk("std_q_unexpected", b0.q, 64'hDEAD_0000_0000);
                else                   chk("std_q", b0.q, 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, '0);
        set_thr(4'd6, 4'd2);
        model_clear();
        repeat (2) @(posedge clock);
        chk("rst_level", b0.level, 0);
        chk("rst_empty", b0.fifo_empty, 1);
        chk("rst_afull", b0.almost_full, 0);
        chk("rst_aempty", b0.almost_empty, 1);
        chk("rst_q", b0.q, 0);
        #1 reset = 1'b0;

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, DW'(32'h11 * i));
        chk("fill_level", b0.level, 8);
        chk("fill_full", b0.fifo_full, 1);
        step(1, 0, 0, 0, 32'h99);
        chk("ovf_set", b0.overflow, 1);
        chk("ovf_level", b0.level, 8);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 1, '0);
        chk("drain_q", b0.q, 32'h88);
        chk("drain_empty", b0.fifo_empty, 1);

        // Pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) step(1, 0, 0, 0, $urandom);
            for (int i = 0; i < 6; i++) step(0, 1, 0, 0, '0);
        end

        // Simultaneous read+write at full and at empty.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, $urandom);
        step(1, 1, 0, 0, 32'hAB);
        chk("full_rw_level", b0.level, 8);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        chk("full_rw_last", b0.q, 32'hAB);
        step(1, 1, 0, 0, 32'hCD);
        chk("empty_rw_udf", b0.underflow, 1);
        chk("empty_rw_level", b0.level, 1);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        chk("empty_rw_q", b0.q, 32'hCD);
        step(0, 1, 0, 1, '0);
        chk("clr_vs_udf", b0.underflow, 1);
        step(0, 0, 0, 1, '0);

        // FWFT visibility, then flush with a concurrent write.
        step(1, 0, 0, 0, 32'h5A);
        chk("fwft_show", b1.q, 32'h5A);
        step(0, 1, 0, 0, '0);
        chk("fwft_pop_empty", b1.fifo_empty, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, $urandom);
        step(1, 0, 1, 0, 32'h77);
        chk("flush_level", b0.level, 0);
        chk("flush_ovf", b0.overflow, 0);
        chk("flush_q", b0.q, 0);

        // Random traffic with moving thresholds.
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) set_thr(4'($urandom_range(15)), 4'($urandom_range(15)));
            step($urandom_range(99) < 55, $urandom_range(99) < 45,
                 $urandom_range(31) == 0, $urandom_range(15) == 0, $urandom);
        end
        repeat (3) step(0, 0, 0, 0, '0);
        chk("sb_drain", 64'(exp_q.size()), 0);

        // Asynchronous reset mid-burst with an error flag set.
        set_thr(4'd6, 4'd2);
        step(0, 0, 1, 1, '0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, $urandom);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0);
        chk("pre_rst_level", b0.level, 4);
        chk("pre_rst_ovf", b0.overflow, 1);
        drive(1, 0, 0, 0, $urandom);
        #2 reset = 1'b1;
        #1;
        chk("arst_level", b0.level, 0);
        chk("arst_level_fwft", b1.level, 0);
        chk("arst_empty", b0.fifo_empty, 1);
        chk("arst_ovf", b0.overflow, 0);
        chk("arst_udf", b0.underflow, 0);
        chk("arst_q", b0.q, 0);
        model_clear();
        drive(0, 0, 0, 0, '0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) step(0, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
